// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial adder/subtractor. A single full-adder cell with a
//               registered carry consumes one operand bit pair per cycle,
//               LSB first, and assembles a WIDTH-bit result over WIDTH
//               cycles. Handshake is start / busy / done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    // Bit counter only ever needs to reach WIDTH-1
    localparam int                 C_CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(WIDTH - 1);

    // Two-state controller
    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [C_CNT_W-1:0] r_cnt;
    // Holds the WIDTH-1 low result bits produced so far; the final bit comes
    // straight from the adder cell on the completing edge.
    logic [WIDTH-2:0] r_res_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_done;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-2:0] w_res_sh_next;
    logic [WIDTH-1:0] w_result_full;
    logic             w_last;

    // Full-adder cell on the current LSBs and the registered carry
    always_comb begin
        w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    end

    // Partial-result shift: new sum bit enters at the top
    generate
        if (WIDTH == 2) begin : g_res_narrow
            assign w_res_sh_next = w_s;
        end else begin : g_res_wide
            assign w_res_sh_next = {w_s, r_res_sh[WIDTH-2:1]};
        end
    endgenerate

    assign w_result_full = {w_s, r_res_sh};
    assign w_last        = (r_cnt == C_LAST);

    // Controller, operand shifters, carry, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_res_sh   <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert b, seed carry with 1
                        r_a_sh   <= a;
                        r_b_sh   <= sub ? ~b : b;
                        r_carry  <= sub;
                        r_res_sh <= '0;
                        r_cnt    <= '0;
                        r_state  <= C_RUN;
                    end
                end
                C_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= w_res_sh_next;
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + C_CNT_ONE;
                    if (w_last) begin
                        // r_carry here is the carry into the sign bit
                        r_result   <= w_result_full;
                        r_cout     <= w_c;
                        r_overflow <= r_carry ^ w_c;
                        r_done     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= C_IDLE;
                    end
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == C_RUN);
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
